fsm_controle_param: RTL and testbench

//  Parametrised successor of the sensor-triggered motor controller. Generalises
//  the run time, cooldown, prescaler, sensor polarity and timer width. Adds an

---
 rtl/fsm_controle_param.sv | 163 ++++++++++++++++
 tb/tb_fsm_controle_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_controle_param.sv
// Sensor-triggered motor controller: synchroniser + debouncer on the raw sensor,
// 1 Hz prescaler, run/cooldown timing with stop and optional retrigger.
//
//   state | meaning
//   IDLE  | motor off, waiting for a debounced sensor rising edge
//   RUN   | motor on, timer_val counts remaining run seconds
//   COOL  | motor off, post-run lockout, sensor edges ignored
module fsm_controle_param #(
  parameter int CLK_FREQ     = 27_000_000,
  parameter int ON_TIME      = 20,
  parameter int COOLDOWN     = 0,
  parameter int TIMER_W      = 5,
  parameter int DEBOUNCE_CYC = 1024,
  parameter int SENSOR_ACT   = 1,
  parameter int RETRIGGER    = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_in,
  input  logic               stop,
  output logic               motor_on,
  output logic [TIMER_W-1:0] timer_val,
  output logic [1:0]         state_out,
  output logic               sensor_db,
  output logic               done
);

  localparam int PRESC_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TIMER_W-1:0] ON_VAL     = TIMER_W'(ON_TIME);
  localparam logic [TIMER_W-1:0] COOL_VAL   = TIMER_W'(COOLDOWN);
  localparam logic [TIMER_W-1:0] ONE_T      = TIMER_W'(1);
  localparam logic               ACT_LVL    = (SENSOR_ACT != 0);
  localparam logic               RETRIG_EN  = (RETRIGGER != 0);
  localparam logic               COOL_EN    = (COOLDOWN != 0);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, COOL = 2'b10} state_t;

  state_t             state, state_n;
  logic               sync1, sync2, sens_norm;
  logic [DB_W-1:0]    db_cnt;
  logic               db_prev, trig_q;
  logic [PRESC_W-1:0] presc, presc_n;
  logic               tick, presc_clr;
  logic [TIMER_W-1:0] timer_n;
  logic               motor_n, done_n;

  assign sens_norm = sync2 ^ ~ACT_LVL;
  assign tick      = (presc == PRESC_LAST);
  assign state_out = state;

  // Edge detect is registered so the FSM sees trig two clocks after sensor_db rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db_cnt    <= '0;
      sensor_db <= 1'b0;
      db_prev   <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      sync1   <= sensor_in;
      sync2   <= sync1;
      db_prev <= sensor_db;
      trig_q  <= sensor_db & ~db_prev;
      if (sens_norm == sensor_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt    <= '0;
        sensor_db <= ~sensor_db;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer_val <= '0;
      motor_on  <= 1'b0;
      done      <= 1'b0;
      presc     <= '0;
    end else begin
      state     <= state_n;
      timer_val <= timer_n;
      motor_on  <= motor_n;
      done      <= done_n;
      presc     <= presc_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer_val;
    motor_n   = motor_on;
    done_n    = 1'b0;
    presc_clr = 1'b0;
    case (state)
      IDLE: begin
        motor_n = 1'b0;
        timer_n = '0;
        if (!stop && trig_q) begin
          state_n   = RUN;
          timer_n   = ON_VAL;
          motor_n   = 1'b1;
          presc_clr = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          timer_n = '0;
          motor_n = 1'b0;
        end else if (trig_q && RETRIG_EN) begin
          timer_n   = ON_VAL;
          presc_clr = 1'b1;
        end else if (tick) begin
          if (timer_val > ONE_T) begin
            timer_n = timer_val - ONE_T;
          end else begin
            done_n  = 1'b1;
            motor_n = 1'b0;
            if (COOL_EN) begin
              state_n   = COOL;
              timer_n   = COOL_VAL;
              presc_clr = 1'b1;
            end else begin
              state_n = IDLE;
              timer_n = '0;
            end
          end
        end
      end
      COOL: begin
        motor_n = 1'b0;
        if (stop) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (tick) begin
          if (timer_val > ONE_T) begin
            timer_n = timer_val - ONE_T;
          end else begin
            state_n = IDLE;
            timer_n = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
        motor_n = 1'b0;
      end
    endcase

    if (presc_clr || tick || state_n == IDLE) presc_n = '0;
    else                                        presc_n = presc + PRESC_W'(1);
  end

endmodule

// File: tb/tb_fsm_controle_param.sv
// Bench for fsm_controle_param: three instances (retrigger off/on, and active-low
// sensor without cooldown) against a deadline-based reference model.
module tb_fsm_controle_param;

  localparam int CF  = 10;
  localparam int ON  = 3;
  localparam int TW  = 5;
  localparam int DBC = 4;
  localparam int NI  = 3;

  int cd_p     [NI] = '{2, 2, 0};
  int rt_p     [NI] = '{0, 1, 0};
  bit rst_norm [NI] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sensor = 1'b0;
  logic stop = 1'b0;
  logic sensor_n;
  assign sensor_n = ~sensor;

  logic [NI-1:0] motor_v, db_v, done_v;
  logic [TW-1:0] timer_v [NI];
  logic [1:0]    state_v [NI];

  fsm_controle_param #(.CLK_FREQ(CF), .ON_TIME(ON), .COOLDOWN(2), .TIMER_W(TW),
    .DEBOUNCE_CYC(DBC), .SENSOR_ACT(1), .RETRIGGER(0)) u0 (
    .clk(clk), .reset(reset), .sensor_in(sensor), .stop(stop),
    .motor_on(motor_v[0]), .timer_val(timer_v[0]), .state_out(state_v[0]),
    .sensor_db(db_v[0]), .done(done_v[0]));

  fsm_controle_param #(.CLK_FREQ(CF), .ON_TIME(ON), .COOLDOWN(2), .TIMER_W(TW),
    .DEBOUNCE_CYC(DBC), .SENSOR_ACT(1), .RETRIGGER(1)) u1 (
    .clk(clk), .reset(reset), .sensor_in(sensor), .stop(stop),
    .motor_on(motor_v[1]), .timer_val(timer_v[1]), .state_out(state_v[1]),
    .sensor_db(db_v[1]), .done(done_v[1]));

  fsm_controle_param #(.CLK_FREQ(CF), .ON_TIME(ON), .COOLDOWN(0), .TIMER_W(TW),
    .DEBOUNCE_CYC(DBC), .SENSOR_ACT(0), .RETRIGGER(0)) u2 (
    .clk(clk), .reset(reset), .sensor_in(sensor_n), .stop(stop),
    .motor_on(motor_v[2]), .timer_val(timer_v[2]), .state_out(state_v[2]),
    .sensor_db(db_v[2]), .done(done_v[2]));

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sensor level normalised to 1 = active for every instance.
  // Run/cool timing is tracked as an absolute deadline cycle; remaining seconds
  // are the ceiling of the cycles left divided by CF.
  longint cyc = 0;
  bit     model_ok = 1'b0;
  bit     s1 [NI], s2 [NI], m_db [NI], dh1 [NI], dh2 [NI], dh3 [NI], m_done [NI];
  int     run_len [NI];
  int     mode [NI];
  longint end_c [NI];

  task automatic model_update();
    bit synced, trig;
    if (reset) begin
      model_ok = 1'b1;
      for (int i = 0; i < NI; i++) begin
        s1[i] = rst_norm[i]; s2[i] = rst_norm[i];
        m_db[i] = 1'b0; dh1[i] = 1'b0; dh2[i] = 1'b0; dh3[i] = 1'b0;
        run_len[i] = 0; mode[i] = 0; m_done[i] = 1'b0; end_c[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < NI; i++) begin
        synced = s2[i]; s2[i] = s1[i]; s1[i] = sensor;
        trig = dh2[i] & ~dh3[i];
        if (synced != m_db[i]) begin
          run_len[i]++;
          if (run_len[i] == DBC) begin m_db[i] = ~m_db[i]; run_len[i] = 0; end
        end else run_len[i] = 0;
        dh3[i] = dh2[i]; dh2[i] = dh1[i]; dh1[i] = m_db[i];
        m_done[i] = 1'b0;
        case (mode[i])
          0: if (!stop && trig) begin mode[i] = 1; end_c[i] = cyc + ON * CF; end
          1: begin
            if (stop) mode[i] = 0;
            else if (trig && rt_p[i] != 0) end_c[i] = cyc + ON * CF;
            else if (cyc == end_c[i]) begin
              m_done[i] = 1'b1;
              if (cd_p[i] > 0) begin mode[i] = 2; end_c[i] = cyc + cd_p[i] * CF; end
              else mode[i] = 0;
            end
          end
          2: if (stop || cyc == end_c[i]) mode[i] = 0;
          default: mode[i] = 0;
        endcase
      end
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_update();
      #1;
    end
  endtask

  task automatic wait_run(input int budget);
    int n;
    n = 0;
    while (state_v[0] != 2'd1 && n < budget) begin step(1); n++; end
    chk("wait_run u0 state", int'(state_v[0]), 1);
  endtask

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      for (int i = 0; i < NI; i++) begin
        int exp_t;
        exp_t = (mode[i] != 0) ? int'((end_c[i] - cyc + CF - 1) / CF) : 0;
        chk($sformatf("u%0d state_out", i), int'(state_v[i]), mode[i]);
        chk($sformatf("u%0d motor_on", i), int'(motor_v[i]), int'(mode[i] == 1));
        chk($sformatf("u%0d timer_val", i), int'(timer_v[i]), exp_t);
        chk($sformatf("u%0d done", i), int'(done_v[i]), int'(m_done[i]));
        chk($sformatf("u%0d sensor_db", i), int'(db_v[i]), int'(m_db[i]));
      end
    end
  end

  initial begin
    int hold;
    reset = 1'b1; sensor = 1'b0; stop = 1'b0;
    step(3);
    chk("reset state", int'(state_v[0]), 0);
    chk("reset motor", int'(motor_v[0]), 0);
    chk("reset timer", int'(timer_v[0]), 0);
    chk("reset done", int'(done_v[0]), 0);

    // Basic run: debounce latency 6, motor 2 clocks later, 3 s run, 2 s cooldown.
    reset = 1'b0; sensor = 1'b1;
    step(5); chk("db at 5", int'(db_v[0]), 0);
    step(1); chk("db at 6", int'(db_v[0]), 1);
    step(1); chk("motor at 7", int'(motor_v[0]), 0);
    step(1); chk("motor at 8", int'(motor_v[0]), 1);
    chk("timer at 8", int'(timer_v[0]), 3);
    step(9); chk("timer at 17", int'(timer_v[0]), 3);
    step(1); chk("timer at 18", int'(timer_v[0]), 2);
    step(20);
    chk("done at 38", int'(done_v[0]), 1);
    chk("state at 38", int'(state_v[0]), 2);
    chk("cool timer at 38", int'(timer_v[0]), 2);
    chk("u2 no-cool state at 38", int'(state_v[2]), 0);
    step(1); chk("done at 39", int'(done_v[0]), 0);
    step(18); chk("state at 57", int'(state_v[0]), 2);
    step(1); chk("state at 58", int'(state_v[0]), 0);
    step(15); chk("held level no restart", int'(state_v[0]), 0);

    // Three-cycle glitch must not pass the debouncer.
    sensor = 1'b0; step(12);
    sensor = 1'b1; step(3);
    sensor = 1'b0; step(12);
    chk("glitch db", int'(db_v[0]), 0);
    chk("glitch motor", int'(motor_v[0]), 0);

    // New edge reaching the FSM while timer_val is 1.
    sensor = 1'b1; wait_run(40);
    sensor = 1'b0; step(14);
    sensor = 1'b1; step(8);
    chk("retrig u1 timer", int'(timer_v[1]), 3);
    chk("no retrig u0 timer", int'(timer_v[0]), 1);
    step(8);
    chk("u0 expiry done", int'(done_v[0]), 1);
    chk("u1 no done", int'(done_v[1]), 0);
    chk("u1 still running", int'(motor_v[1]), 1);
    chk("u1 timer after reload", int'(timer_v[1]), 3);
    sensor = 1'b0; step(62);
    chk("u1 back idle", int'(state_v[1]), 0);

    // Stop in RUN at timer 2, then stop coinciding with a trigger in IDLE.
    sensor = 1'b1; wait_run(40);
    step(10); chk("timer before stop", int'(timer_v[0]), 2);
    stop = 1'b1; step(1);
    chk("stop state", int'(state_v[0]), 0);
    chk("stop motor", int'(motor_v[0]), 0);
    chk("stop done", int'(done_v[0]), 0);
    stop = 1'b0;
    sensor = 1'b0; step(10);
    stop = 1'b1; sensor = 1'b1; step(12);
    stop = 1'b0; step(3);
    chk("stop+trig idle", int'(state_v[0]), 0);

    // Reset in the middle of a run.
    sensor = 1'b0; step(10);
    sensor = 1'b1; wait_run(40);
    step(10); chk("timer before reset", int'(timer_v[0]), 2);
    reset = 1'b1; sensor = 1'b0; step(1);
    chk("midrun reset motor", int'(motor_v[0]), 0);
    chk("midrun reset timer", int'(timer_v[0]), 0);
    chk("midrun reset state", int'(state_v[0]), 0);
    chk("midrun reset done", int'(done_v[0]), 0);
    reset = 1'b0; step(10);

    // Edge during COOL ignored, level held through COOL exit does not restart.
    sensor = 1'b1; wait_run(40);
    sensor = 1'b0; step(24);
    sensor = 1'b1; step(10);
    chk("cool state", int'(state_v[0]), 2);
    chk("cool timer", int'(timer_v[0]), 2);
    step(30);
    chk("after cool idle", int'(state_v[0]), 0);
    chk("after cool motor", int'(motor_v[0]), 0);

    // Random sensor runs with occasional stop and reset.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        sensor = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 25));
      end
      hold--;
      stop  = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 599) == 0);
      step(1);
    end
    reset = 1'b0; stop = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
